// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU opcode encoding and helpers.
// Imported by the MDU controller, its datapath and the decoder.
package mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  function automatic logic is_mul(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_long(input logic [3:0] op);
    return is_mul(op) || is_div(op);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath for the MDU.
// Results are captured by mdu_ctrl into its pending registers.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic [31:0] res_hi_o,
  output logic [31:0] res_lo_o,
  output logic        div_zero_o
);

  md_op_e             op;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic               sdiv;
  logic               neg_a;
  logic               neg_b;
  logic [31:0]        mag_a;
  logic [31:0]        mag_b;
  logic [31:0]        den;
  logic [31:0]        q_u;
  logic [31:0]        r_u;
  logic [31:0]        quo;
  logic [31:0]        rem;

  assign op = md_op_e'(op_i);

  assign prod_s = 64'($signed(rs_i)) * 64'($signed(rt_i));
  assign prod_u = 64'(rs_i) * 64'(rt_i);

  // Divide on magnitudes so -2^31 / -1 wraps to 0x80000000 cleanly.
  assign sdiv       = (op == MD_DIV);
  assign neg_a      = sdiv & rs_i[31];
  assign neg_b      = sdiv & rt_i[31];
  assign mag_a      = neg_a ? (32'd0 - rs_i) : rs_i;
  assign mag_b      = neg_b ? (32'd0 - rt_i) : rt_i;
  assign div_zero_o = (rt_i == 32'd0);
  assign den        = div_zero_o ? 32'd1 : mag_b;
  assign q_u        = mag_a / den;
  assign r_u        = mag_a % den;
  assign quo        = (neg_a ^ neg_b) ? (32'd0 - q_u) : q_u;
  assign rem        = neg_a ? (32'd0 - r_u) : r_u;

  always_comb begin
    res_hi_o = 32'd0;
    res_lo_o = 32'd0;
    unique case (op)
      MD_MULT: begin
        res_hi_o = prod_s[63:32];
        res_lo_o = prod_s[31:0];
      end
      MD_MULTU: begin
        res_hi_o = prod_u[63:32];
        res_lo_o = prod_u[31:0];
      end
      MD_DIV, MD_DIVU: begin
        res_hi_o = rem;
        res_lo_o = quo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide sequencer: owns HI/LO, the busy window
// and the stall request that holds MDU ops in D while busy.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  e_md_op,
  input  logic        e_valid,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_op_e             op;
  logic [31:0]        res_hi;
  logic [31:0]        res_lo;
  logic               div_zero;

  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic [31:0]        phi_q, phi_d;
  logic [31:0]        plo_q, plo_d;
  logic               pwr_q, pwr_d;

  assign op = md_op_e'(e_md_op);

  mdu_arith u_arith (
    .op_i       (e_md_op),
    .rs_i       (e_rs),
    .rt_i       (e_rt),
    .res_hi_o   (res_hi),
    .res_lo_o   (res_lo),
    .div_zero_o (div_zero)
  );

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    phi_d  = phi_q;
    plo_d  = plo_q;
    pwr_d  = pwr_q;
    if (busy_q) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        if (pwr_q) begin
          hi_d = phi_q;
          lo_d = plo_q;
        end
      end
    end else if (e_valid) begin
      unique case (1'b1)
        is_mul(e_md_op): begin
          phi_d  = res_hi;
          plo_d  = res_lo;
          pwr_d  = 1'b1;
          cnt_d  = CNT_W'(MUL_CYCLES);
          busy_d = 1'b1;
        end
        is_div(e_md_op): begin
          phi_d  = res_hi;
          plo_d  = res_lo;
          pwr_d  = !div_zero;
          cnt_d  = CNT_W'(DIV_CYCLES);
          busy_d = 1'b1;
        end
        (op == MD_MTHI): hi_d = e_rs;
        (op == MD_MTLO): lo_d = e_rs;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      phi_q  <= '0;
      plo_q  <= '0;
      pwr_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      phi_q  <= phi_d;
      plo_q  <= plo_d;
      pwr_q  <= pwr_d;
    end
  end

  always_comb begin
    md_out = 32'd0;
    unique case (op)
      MD_MFHI: md_out = hi_q;
      MD_MFLO: md_out = lo_q;
      default: ;
    endcase
  end

  assign stall_req = d_md_use &&
                     (busy_q || (e_valid && is_long(e_md_op)));
  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected HI/LO and busy length
// are queued at issue and compared when the unit goes idle.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  e_md_op;
  logic        e_valid;
  logic [31:0] e_rs;
  logic [31:0] e_rt;
  logic        d_md_use;
  logic        busy;
  logic        stall_req;
  logic [31:0] md_out;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] m_hi   = 32'd0;
  logic [31:0] m_lo   = 32'd0;

  mdu_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .e_md_op   (e_md_op),
    .e_valid   (e_valid),
    .e_rs      (e_rs),
    .e_rt      (e_rt),
    .d_md_use  (d_md_use),
    .busy      (busy),
    .stall_req (stall_req),
    .md_out    (md_out),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic idle_in();
    e_valid = 1'b0;
    e_md_op = MD_NONE;
    e_rs    = 32'd0;
    e_rt    = 32'd0;
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    e_md_op = op;
    e_valid = 1'b1;
    e_rs    = v;
    @(posedge clk); #1;
    idle_in();
    if (op == MD_MTHI) m_hi = v;
    else m_lo = v;
  endtask

  task automatic mf(input string tag, input logic [3:0] op,
                    input logic [31:0] exp);
    e_md_op = op;
    e_valid = 1'b1;
    #1;
    chk(tag, md_out, exp);
    idle_in();
    #1;
  endtask

  task automatic run_long(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input bit use_d, input bit inj);
    exp_t        e;
    exp_t        g;
    logic [63:0] p;
    longint      sa;
    longint      sb;
    int          nb;
    int          ns;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    e.hi = m_hi;
    e.lo = m_lo;
    e.n  = 10;
    case (op)
      MD_MULT: begin
        p = sa * sb;
        e.hi = p[63:32]; e.lo = p[31:0]; e.n = 5;
      end
      MD_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        e.hi = p[63:32]; e.lo = p[31:0]; e.n = 5;
      end
      MD_DIV: if (b != 0) begin
        p = sa / sb; e.lo = p[31:0];
        p = sa % sb; e.hi = p[31:0];
      end
      MD_DIVU: if (b != 0) begin
        p = {32'd0, a} / {32'd0, b}; e.lo = p[31:0];
        p = {32'd0, a} % {32'd0, b}; e.hi = p[31:0];
      end
      default: ;
    endcase
    sb_q.push_back(e);
    d_md_use = use_d;
    e_md_op  = op;
    e_rs     = a;
    e_rt     = b;
    e_valid  = 1'b1;
    #1;
    chk({tag, ":stall_issue"}, 32'(stall_req), 32'(use_d));
    @(posedge clk); #1;
    idle_in();
    if (inj) begin
      e_md_op = MD_MTHI;
      e_valid = 1'b1;
      e_rs    = 32'h1234_5678;
    end
    nb = 0;
    ns = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      nb++;
      if (stall_req) ns++;
      @(posedge clk); #1;
      idle_in();
    end
    chk({tag, ":stall_after"}, 32'(stall_req), 32'd0);
    g = sb_q.pop_front();
    chk({tag, ":busy_len"}, 32'(nb), 32'(g.n));
    chk({tag, ":stall_len"}, 32'(ns), use_d ? 32'(g.n) : 32'd0);
    chk({tag, ":hi"}, hi, g.hi);
    chk({tag, ":lo"}, lo, g.lo);
    m_hi = g.hi;
    m_lo = g.lo;
  endtask

  initial begin
    reset    = 1'b1;
    d_md_use = 1'b1;
    idle_in();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst:busy", 32'(busy), 32'd0);
    chk("rst:hi", hi, 32'd0);
    chk("rst:lo", lo, 32'd0);
    chk("rst:stall", 32'(stall_req), 32'd0);
    mf("rst:md_none", MD_NONE, 32'd0);

    e_md_op = MD_MULT; e_rs = 32'd7; e_rt = 32'd9; e_valid = 1'b1;
    @(posedge clk); #1;
    idle_in();
    @(posedge clk); #2;
    chk("mid:busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid:busy_async", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("mid:busy", 32'(busy), 32'd0);
    chk("mid:hi", hi, 32'd0);
    chk("mid:lo", lo, 32'd0);
    chk("mid:stall", 32'(stall_req), 32'd0);

    run_long("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    run_long("multu", MD_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    run_long("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_long("divu_st", MD_DIVU, 32'd100, 32'd7, 1'b1, 1'b0);
    run_long("divu_ns", MD_DIVU, 32'hFFFF_FFFF, 32'd16, 1'b0, 1'b0);
    mt(MD_MTHI, 32'h11);
    mt(MD_MTLO, 32'h22);
    run_long("div0", MD_DIV, 32'd55, 32'd0, 1'b1, 1'b0);
    run_long("divov", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    mt(MD_MTLO, 32'hDEAD_BEEF);
    mf("mflo", MD_MFLO, 32'hDEAD_BEEF);
    mf("mfhi", MD_MFHI, m_hi);
    run_long("ign", MD_MULT, 32'h0001_0000, 32'h0003_0000, 1'b1, 1'b1);
    run_long("b2b", MD_MULTU, 32'h8000_0001, 32'd6, 1'b1, 1'b0);
    mf("b2b:mfhi", MD_MFHI, 32'd3);
    mf("b2b:mflo", MD_MFLO, 32'd6);
    chk("sb:empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
